// File: rtl/decoder_n_seq_if.sv
// Select/decode bus for decoder_n_seq: request handshake, scan dwell and one-hot result.
interface decoder_n_seq_if #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
);
  logic                  sel_valid;
  logic [SEL_W-1:0]      sel;
  logic                  sel_ready;
  logic [DWELL_W-1:0]    dwell;
  logic [(2**SEL_W)-1:0] y;
  logic                  y_valid;
  logic                  wrap;

  modport master (
    output sel_valid, sel, dwell,
    input  sel_ready, y, y_valid, wrap
  );

  modport slave (
    input  sel_valid, sel, dwell,
    output sel_ready, y, y_valid, wrap
  );
endinterface

// File: rtl/decoder_n_seq.sv
// Registered one-hot decoder with a DIRECT handshake mode and a SCAN auto-sequencer
// that steps through every output, holding each for dwell+1 cycles.
module decoder_n_seq #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            mode,
  decoder_n_seq_if.slave  bus
);
  localparam int unsigned N = 2**SEL_W;
  localparam logic [N-1:0] Y_ONE = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       y_q, y_d;
  logic               y_valid_q, y_valid_d;
  logic               wrap_q, wrap_d;
  logic [SEL_W-1:0]   idx_q, idx_d, idx_inc;
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    if (en) state_d = mode ? SCAN : DIRECT;
  end

  // Outputs are registered, so they are computed from the state being entered.
  always_comb begin
    y_d       = y_q;
    y_valid_d = y_valid_q;
    wrap_d    = 1'b0;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    idx_inc   = idx_q + SEL_W'(1);
    case (state_d)
      DIRECT: begin
        idx_d = '0;
        cnt_d = '0;
        if (state_q == DIRECT && bus.sel_valid) begin
          y_d       = Y_ONE << bus.sel;
          y_valid_d = 1'b1;
        end
      end
      SCAN: begin
        if (state_q != SCAN) begin
          idx_d     = '0;
          cnt_d     = '0;
          y_d       = Y_ONE;
          y_valid_d = 1'b1;
        end else if (cnt_q == bus.dwell) begin
          cnt_d  = '0;
          idx_d  = idx_inc;
          y_d    = Y_ONE << idx_inc;
          wrap_d = (idx_q == '1);
        end else begin
          // A dwell lowered below cnt_q lets the counter roll over naturally.
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      default: begin
        y_d       = '0;
        y_valid_d = 1'b0;
        idx_d     = '0;
        cnt_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      wrap_q    <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      wrap_q    <= wrap_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.sel_ready = (state_q == DIRECT);
  assign bus.y         = y_q;
  assign bus.y_valid   = y_valid_q;
  assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_decoder_n_seq.sv
// Bench for decoder_n_seq: cycle-by-cycle model comparison plus directed literal checks.
module tb_decoder_n_seq;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n, en, mode, en3, mode3;
  int   tests = 0;
  int   fails = 0;
  bit   model_en = 1'b1;

  always #5 clk = ~clk;

  decoder_n_seq_if #(.SEL_W(2), .DWELL_W(8)) bus ();
  decoder_n_seq_if #(.SEL_W(3), .DWELL_W(8)) bus3 ();

  decoder_n_seq #(.SEL_W(2), .DWELL_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .bus(bus)
  );
  decoder_n_seq #(.SEL_W(3), .DWELL_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .mode(mode3), .bus(bus3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: 0=idle 1=direct 2=scan; scan position derived from cycles since entry.
  int m_st, m_idx, scan_t;
  bit m_valid, m_wrap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_idx = 0; m_valid = 0; m_wrap = 0; scan_t = 0;
    end else if (!en) begin
      m_st = 0; m_idx = 0; m_valid = 0; m_wrap = 0;
    end else if (mode) begin
      if (m_st != 2) scan_t = 0;
      else           scan_t++;
      m_idx   = (scan_t / (int'(bus.dwell) + 1)) % N;
      m_wrap  = (scan_t > 0) && (scan_t % ((int'(bus.dwell) + 1) * N) == 0);
      m_valid = 1;
      m_st    = 2;
    end else begin
      if (m_st == 1 && bus.sel_valid) begin
        m_idx   = int'(bus.sel);
        m_valid = 1;
      end
      m_wrap = 0;
      m_st   = 1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (model_en) begin
      chk("model_y", 64'(bus.y), m_valid ? (64'd1 << m_idx) : 64'd0);
      chk("model_y_valid", 64'(bus.y_valid), 64'(m_valid));
      chk("model_wrap", 64'(bus.wrap), 64'(m_wrap));
      chk("model_sel_ready", 64'(bus.sel_ready), 64'(m_st == 1));
      chk("onehot", 64'($countones(bus.y) <= 1), 64'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [3:0] exp31 [4];
  logic [3:0] exp32 [13];
  int n;

  initial begin
    exp31 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp32 = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4,
              4'h8, 4'h8, 4'h8, 4'h1};
    rst_n = 0; en = 0; mode = 0; en3 = 0; mode3 = 0;
    bus.sel_valid = 0; bus.sel = '0; bus.dwell = '0;
    bus3.sel_valid = 0; bus3.sel = '0; bus3.dwell = '0;
    tick(); tick();
    chk("rst_y", 64'(bus.y), 64'd0);
    chk("rst_y_valid", 64'(bus.y_valid), 64'd0);
    chk("rst_sel_ready", 64'(bus.sel_ready), 64'd0);
    chk("rst_wrap", 64'(bus.wrap), 64'd0);
    rst_n = 1;
    tick();

    // DIRECT sweep, back-to-back handshakes
    en = 1; mode = 0;
    tick();
    chk("direct_first_y", 64'(bus.y), 64'd0);
    chk("direct_first_ready", 64'(bus.sel_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      bus.sel_valid = 1; bus.sel = 2'(i);
      tick();
      chk("direct_sweep_y", 64'(bus.y), 64'(exp31[i]));
      chk("direct_sweep_valid", 64'(bus.y_valid), 64'd1);
    end
    bus.sel_valid = 0;
    tick();
    chk("direct_hold_y", 64'(bus.y), 64'h8);

    // en drop with a pending request
    bus.sel_valid = 1; bus.sel = 2'd1; en = 0;
    tick();
    chk("endrop_y", 64'(bus.y), 64'd0);
    chk("endrop_ready", 64'(bus.sel_ready), 64'd0);
    bus.sel_valid = 0; en = 1;
    tick();
    chk("endrop_not_queued", 64'(bus.y), 64'd0);

    // SCAN dwell=2
    bus.dwell = 8'd2; mode = 1;
    for (int i = 0; i < 13; i++) begin
      tick();
      chk("scan2_y", 64'(bus.y), 64'(exp32[i]));
      chk("scan2_wrap", 64'(bus.wrap), 64'(i == 12));
    end
    tick();
    chk("scan2_wrap_once", 64'(bus.wrap), 64'd0);

    // SCAN dwell=0
    en = 0;
    tick();
    en = 1; bus.dwell = 8'd0;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("scan0_y", 64'(bus.y), 64'd1 << (i % 4));
      chk("scan0_wrap", 64'(bus.wrap), 64'(i > 0 && i % 4 == 0));
    end

    // SCAN -> DIRECT switch
    en = 0;
    tick();
    en = 1;
    tick(); tick(); tick();
    chk("switch_scan_y", 64'(bus.y), 64'h4);
    mode = 0;
    tick();
    chk("switch_hold_y", 64'(bus.y), 64'h4);
    chk("switch_hold_valid", 64'(bus.y_valid), 64'd1);
    chk("switch_ready", 64'(bus.sel_ready), 64'd1);
    bus.sel_valid = 1; bus.sel = 2'd3;
    tick();
    chk("switch_hs_y", 64'(bus.y), 64'h8);
    bus.sel_valid = 0;

    // async reset mid-dwell
    mode = 1; bus.dwell = 8'd3;
    tick(); tick();
    #3 rst_n = 0;
    #1;
    chk("async_y", 64'(bus.y), 64'd0);
    chk("async_valid", 64'(bus.y_valid), 64'd0);
    chk("async_ready", 64'(bus.sel_ready), 64'd0);
    tick();
    rst_n = 1;
    tick();
    chk("resume_y", 64'(bus.y), 64'h1);
    chk("resume_valid", 64'(bus.y_valid), 64'd1);
    chk("resume_wrap", 64'(bus.wrap), 64'd0);

    // dwell lowered below the running count: no early advance
    en = 0;
    tick();
    model_en = 0;
    en = 1; bus.dwell = 8'd5;
    tick(); tick(); tick(); tick();
    chk("lower_pre_y", 64'(bus.y), 64'h1);
    bus.dwell = 8'd1;
    n = 0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      n = k;
      if (bus.y != 4'h1) break;
    end
    chk("lower_cycles", 64'(n), 64'd255);
    chk("lower_y", 64'(bus.y), 64'h2);
    en = 0;
    tick();
    model_en = 1;

    // SEL_W=3 DIRECT sweep
    en3 = 1;
    tick();
    for (int i = 0; i < 8; i++) begin
      bus3.sel_valid = 1; bus3.sel = 3'(i);
      tick();
      chk("sel3_y", 64'(bus3.y), 64'd1 << i);
      chk("sel3_valid", 64'(bus3.y_valid), 64'd1);
    end
    bus3.sel_valid = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/decoder_n_seq.md
DECODER_N_SEQ -- requirements
Module: decoder_n_seq

Interface
REQ-001 SHALL provide parameter SEL_W, default 2, giving select width and 2**SEL_W one-hot outputs (legal 1..6).
REQ-002 SHALL provide parameter DWELL_W, default 8, giving width of the scan dwell count.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  block enable; 0 forces IDLE.
REQ-007 mode  input  1  0 = DIRECT decode, 1 = SCAN (auto-sequence).
REQ-008 sel_valid  input  1  select request valid (DIRECT only).
REQ-009 sel  input  SEL_W  select index to decode.
REQ-010 sel_ready  output  1  block accepts sel this cycle.
REQ-011 dwell  input  DWELL_W  SCAN: cycles each output stays active is dwell+1.
REQ-012 y  output  2**SEL_W  registered one-hot (or all-zero) decode.
REQ-013 y_valid  output  1  y holds a valid one-hot code.
REQ-014 wrap  output  1  one-cycle pulse when SCAN index wraps to 0.

Function
REQ-015 SHALL implement states IDLE, DIRECT, SCAN; next state each edge: en=0 -> IDLE; en=1,mode=0 -> DIRECT; en=1,mode=1 -> SCAN.
REQ-016 IDLE: y=0, y_valid=0, wrap=0, sel_ready=0, index and dwell counter held at 0 on the edge entering IDLE.
REQ-017 sel_ready SHALL be combinational: 1 only when state=DIRECT.
REQ-018 DIRECT: handshake completes when sel_valid & sel_ready at an edge; on that edge y <= 1<<sel, y_valid <= 1; latency exactly 1 cycle.
REQ-019 DIRECT: with no handshake, y and y_valid SHALL hold; first cycle in DIRECT after IDLE shows y=0, y_valid=0 until first handshake.
REQ-020 DIRECT: back-to-back handshakes on consecutive cycles SHALL each update y on the following edge (full throughput).
REQ-021 Entering SCAN (from IDLE or DIRECT) SHALL load index=0, dwell counter=0, and drive y=1<<0, y_valid=1 on that edge.
REQ-022 SCAN: dwell counter increments each cycle; when counter==dwell, counter <= 0 and index <= index+1 mod 2**SEL_W, y updated same edge.
REQ-023 dwell=0 SHALL advance index every cycle; dwell sampled each cycle, a change applies to the current comparison immediately.
REQ-024 If dwell is lowered below the current counter value, the counter SHALL continue to its natural wrap at 2**DWELL_W-1, then 0 (no early advance).
REQ-025 wrap SHALL be 1 for exactly the cycle in which y first shows index 0 after index 2**SEL_W-1; not asserted on SCAN entry.
REQ-026 SCAN -> DIRECT SHALL hold the last scanned y, y_valid=1, until the next handshake.
REQ-027 sel_valid and sel SHALL be ignored outside DIRECT; no request is queued.
REQ-028 y SHALL never have more than one bit set in any cycle.

Reset
REQ-029 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, y=0, y_valid=0, wrap=0, sel_ready=0, index=0, dwell counter=0.
REQ-030 Reset deassertion SHALL take effect on the next rising clk; reset mid-scan or mid-handshake SHALL discard all progress.

Verification (SEL_W=2, DWELL_W=8)
REQ-031 DIRECT sweep: en=1,mode=0, sel=0,1,2,3 with sel_valid=1 back-to-back -> y=0001,0010,0100,1000 one cycle after each, y_valid=1.
REQ-032 SCAN dwell=2: en=1,mode=1 -> y=0001 x3, 0010 x3, 0100 x3, 1000 x3, 0001 with wrap=1 for that first cycle only.
REQ-033 SCAN dwell=0: y rotates every cycle 0001->0010->0100->1000->0001, wrap pulses every 4th cycle.
REQ-034 Mode switch: scan to y=0100, set mode=0 -> y holds 0100, sel_ready=1; handshake sel=3 -> y=1000 next cycle.
REQ-035 Async reset: assert rst_n=0 mid-dwell between edges -> y=0, y_valid=0 before next clk edge; release -> resume in state chosen by en/mode, SCAN restarting at 0001.
REQ-036 en=0 during DIRECT with sel_valid=1 -> sel_ready=0, y=0 next edge, request dropped; SEL_W=3 build run of REQ-031 shows 8 correct codes.
